// File: rtl/damage_gate_logic.sv
// Damage gate for the player sprite: turns collision levels into single hit / extra-life
// pulses, runs the post-hit invulnerability window with sprite blinking, and latches death.
module damage_gate_logic #(
  parameter logic [7:0] INVULN_FRAMES = 8'd120,
  parameter logic [7:0] BLINK_HALF    = 8'd4
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic collision_explosion,
  input  logic collision_enemy,
  input  logic collision_heart,
  input  logic player_died,
  output logic player_hit,
  output logic increase_heart,
  output logic heart_taken,
  output logic invulnerable,
  output logic player_visible
);

  typedef enum logic [1:0] {StIdle, StHit, StInvuln, StDead} state_e;

  state_e     state_q;
  logic [7:0] frame_cnt_q;
  logic [7:0] blink_cnt_q;
  logic       heart_prev_q;
  logic       heart_pend_q;
  logic       player_hit_q;
  logic       increase_heart_q;
  logic       heart_taken_q;
  logic       invulnerable_q;
  logic       player_visible_q;

  logic damage;
  logic heart_rise;
  logic heart_event;
  logic heart_ok;
  logic last_frame;
  logic blink_wrap;

  always_comb begin
    damage      = collision_explosion | collision_enemy;
    heart_rise  = collision_heart & ~heart_prev_q;
    heart_event = heart_rise | heart_pend_q;
    // A heart seen while a hit is being launched is deferred so the two pulses never overlap
    // and the extra life always follows the damage.
    heart_ok    = (state_q == StInvuln) | ((state_q == StIdle) & ~damage);
    last_frame  = (frame_cnt_q == 8'd1);
    blink_wrap  = (blink_cnt_q == (BLINK_HALF - 8'd1));
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q          <= StIdle;
      frame_cnt_q      <= 8'd0;
      blink_cnt_q      <= 8'd0;
      heart_prev_q     <= 1'b0;
      heart_pend_q     <= 1'b0;
      player_hit_q     <= 1'b1;
      increase_heart_q <= 1'b1;
      heart_taken_q    <= 1'b0;
      invulnerable_q   <= 1'b0;
      player_visible_q <= 1'b1;
    end else begin
      heart_prev_q     <= collision_heart;
      player_hit_q     <= 1'b1;
      increase_heart_q <= 1'b1;
      heart_taken_q    <= 1'b0;

      if (player_died) begin
        state_q          <= StDead;
        frame_cnt_q      <= 8'd0;
        blink_cnt_q      <= 8'd0;
        heart_pend_q     <= 1'b0;
        invulnerable_q   <= 1'b0;
        player_visible_q <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            invulnerable_q   <= 1'b0;
            player_visible_q <= 1'b1;
            if (damage) begin
              state_q <= StHit;
            end
          end
          StHit: begin
            player_hit_q     <= 1'b0;
            frame_cnt_q      <= INVULN_FRAMES;
            blink_cnt_q      <= 8'd0;
            invulnerable_q   <= 1'b1;
            player_visible_q <= 1'b1;
            state_q          <= StInvuln;
          end
          StInvuln: begin
            invulnerable_q <= 1'b1;
            if (startOfFrame) begin
              if (last_frame) begin
                state_q          <= StIdle;
                frame_cnt_q      <= 8'd0;
                blink_cnt_q      <= 8'd0;
                invulnerable_q   <= 1'b0;
                player_visible_q <= 1'b1;
              end else begin
                frame_cnt_q <= frame_cnt_q - 8'd1;
                if (blink_wrap) begin
                  blink_cnt_q      <= 8'd0;
                  player_visible_q <= ~player_visible_q;
                end else begin
                  blink_cnt_q <= blink_cnt_q + 8'd1;
                end
              end
            end
          end
          StDead: begin
            invulnerable_q   <= 1'b0;
            player_visible_q <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase

        if (heart_event) begin
          if (heart_ok) begin
            increase_heart_q <= 1'b0;
            heart_taken_q    <= 1'b1;
            heart_pend_q     <= 1'b0;
          end else if (state_q != StDead) begin
            heart_pend_q <= 1'b1;
          end
        end
      end
    end
  end

  assign player_hit     = player_hit_q;
  assign increase_heart = increase_heart_q;
  assign heart_taken    = heart_taken_q;
  assign invulnerable   = invulnerable_q;
  assign player_visible = player_visible_q;

endmodule

// File: tb/tb_damage_gate_logic.sv
// Directed bench for damage_gate_logic with INVULN_FRAMES=4, BLINK_HALF=2.
module tb_damage_gate_logic;

  logic clk = 1'b0;
  logic resetN;
  logic startOfFrame;
  logic collision_explosion;
  logic collision_enemy;
  logic collision_heart;
  logic player_died;
  logic player_hit;
  logic increase_heart;
  logic heart_taken;
  logic invulnerable;
  logic player_visible;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  damage_gate_logic #(
    .INVULN_FRAMES(8'd4),
    .BLINK_HALF   (8'd2)
  ) dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .collision_explosion(collision_explosion),
    .collision_enemy    (collision_enemy),
    .collision_heart    (collision_heart),
    .player_died        (player_died),
    .player_hit         (player_hit),
    .increase_heart     (increase_heart),
    .heart_taken        (heart_taken),
    .invulnerable       (invulnerable),
    .player_visible     (player_visible)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hit"}, player_hit, 1);
    check({tag, "_inc"}, increase_heart, 1);
    check({tag, "_taken"}, heart_taken, 0);
    check({tag, "_inv"}, invulnerable, 0);
    check({tag, "_vis"}, player_visible, 1);
  endtask

  int hits;
  int hearts;
  int takens;
  int mism;
  int first_hit;
  int second_hit;
  int heart_cyc;
  logic [3:0] vis_exp;

  initial begin
    resetN              = 1'b0;
    startOfFrame        = 1'b0;
    collision_explosion = 1'b0;
    collision_enemy     = 1'b0;
    collision_heart     = 1'b0;
    player_died         = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    resetN = 1'b1;
    tick(1);

    // Single-cycle enemy touch: hit pulse two cycles later, then 4 frames invulnerable.
    collision_enemy = 1'b1;
    tick(1);
    collision_enemy = 1'b0;
    check("hit_not_yet", player_hit, 1);
    tick(1);
    check("hit_pulse", player_hit, 0);
    check("hit_inv", invulnerable, 1);
    check("hit_vis", player_visible, 1);
    tick(1);
    check("hit_one_cycle", player_hit, 1);
    vis_exp = 4'b1001;  // visibility after frames 1..4, LSB = frame 4
    for (int i = 0; i < 4; i++) begin
      startOfFrame = 1'b1;
      tick(1);
      startOfFrame = 1'b0;
      check($sformatf("inv_frame%0d", i + 1), invulnerable, (i < 3) ? 1 : 0);
      check($sformatf("vis_frame%0d", i + 1), player_visible, vis_exp[3 - i]);
      tick(9);
    end
    check("no_rehit", player_hit, 1);

    // Explosion held: second hit comes right after the window closes.
    hits = 0;
    first_hit = -1;
    second_hit = -1;
    collision_explosion = 1'b1;
    for (int c = 0; c < 100; c++) begin
      startOfFrame = (c % 10 == 0);
      if (c >= 75) collision_explosion = 1'b0;
      tick(1);
      if (!player_hit) begin
        hits++;
        if (first_hit < 0) first_hit = c;
        else if (second_hit < 0) second_hit = c;
      end
    end
    startOfFrame = 1'b0;
    check("held_hits", hits, 2);
    check("held_first_cyc", first_hit, 1);
    check("held_second_cyc", second_hit, 42);
    check("held_inv_end", invulnerable, 0);

    // Heart held for 50 cycles: one pulse only.
    hearts = 0;
    takens = 0;
    mism = 0;
    heart_cyc = -1;
    collision_heart = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      if (!increase_heart) begin
        hearts++;
        heart_cyc = c;
      end
      if (heart_taken) takens++;
      if ((!increase_heart) != heart_taken) mism++;
    end
    check("heart_pulses", hearts, 1);
    check("heart_taken_pulses", takens, 1);
    check("heart_coincide", mism, 0);
    check("heart_cyc", heart_cyc, 0);
    collision_heart = 1'b0;
    tick(2);

    // Hit and heart together: hit pulse first, heart on the next cycle.
    collision_enemy = 1'b1;
    collision_heart = 1'b1;
    tick(1);
    collision_enemy = 1'b0;
    check("both_c1_hit", player_hit, 1);
    check("both_c1_inc", increase_heart, 1);
    tick(1);
    check("both_c2_hit", player_hit, 0);
    check("both_c2_inc", increase_heart, 1);
    tick(1);
    check("both_c3_hit", player_hit, 1);
    check("both_c3_inc", increase_heart, 0);
    check("both_c3_taken", heart_taken, 1);
    tick(1);
    check("both_c4_inc", increase_heart, 1);
    check("both_c4_taken", heart_taken, 0);
    collision_heart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      startOfFrame = 1'b1;
      tick(1);
      startOfFrame = 1'b0;
      tick(9);
    end
    check("both_exit_inv", invulnerable, 0);

    // Death during the window with a heart pending: no heart, no more hits.
    collision_enemy = 1'b1;
    collision_heart = 1'b1;
    tick(1);
    collision_enemy = 1'b0;
    tick(1);
    check("dead_pre_hit", player_hit, 0);
    player_died = 1'b1;
    tick(1);
    check("dead_inc", increase_heart, 1);
    check("dead_taken", heart_taken, 0);
    check("dead_hit", player_hit, 1);
    check("dead_inv", invulnerable, 0);
    check("dead_vis", player_visible, 1);
    player_died = 1'b0;
    hits = 0;
    hearts = 0;
    for (int c = 0; c < 30; c++) begin
      collision_enemy = 1'b1;
      collision_explosion = (c >= 10);
      collision_heart = (c >= 5);
      startOfFrame = (c % 10 == 0);
      tick(1);
      if (!player_hit) hits++;
      if (!increase_heart || heart_taken) hearts++;
    end
    check("dead_no_hits", hits, 0);
    check("dead_no_hearts", hearts, 0);
    check("dead_inv_end", invulnerable, 0);
    collision_enemy = 1'b0;
    collision_explosion = 1'b0;
    collision_heart = 1'b0;
    startOfFrame = 1'b0;

    resetN = 1'b0;
    tick(1);
    resetN = 1'b1;
    check_reset_outputs("dead_reset");

    // Reset in the middle of the invulnerability window while the sprite is hidden.
    collision_enemy = 1'b1;
    tick(1);
    collision_enemy = 1'b0;
    tick(1);
    check("rst_pre_hit", player_hit, 0);
    for (int i = 0; i < 2; i++) begin
      startOfFrame = 1'b1;
      tick(1);
      startOfFrame = 1'b0;
      tick(1);
    end
    check("rst_pre_vis", player_visible, 0);
    check("rst_pre_inv", invulnerable, 1);
    resetN = 1'b0;
    tick(1);
    resetN = 1'b1;
    check_reset_outputs("mid_inv_reset");

    // Reset during the HIT cycle suppresses the pulse.
    collision_enemy = 1'b1;
    tick(1);
    collision_enemy = 1'b0;
    resetN = 1'b0;
    tick(1);
    resetN = 1'b1;
    check("rst_hit_suppressed", player_hit, 1);
    check("rst_hit_inv", invulnerable, 0);
    tick(1);
    check("rst_idle_hit", player_hit, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
